// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared control types for the pipeline hazard controller and the stages it drives.
//   ControllerState : sequencer state (2-bit) RUN / MEM_WAIT / REDIRECT
//   StageCtrl       : per-stage {stall, flush} pair consumed by each stage's control interface
//   RegAddr         : architectural register address
package pipeline_hazard_controller_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] RegAddr;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ControllerState;

    typedef struct packed {
        logic stall;
        logic flush;
    } StageCtrl;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use compare: flags when the instruction in decode reads the
// register that a load in execute is about to write. Register 0 never creates a hazard.
//   decRs1Addr/decRs2Addr : decode source registers
//   decUsesRs1/decUsesRs2 : decode actually reads that source
//   exeRdAddr/exeIsLoad   : destination and load flag of the execute instruction
//   hazard                : load-use hazard present this cycle
module pipeline_hazard_controller_load_use_detector
    import pipeline_hazard_controller_pkg::*;
(
    input  RegAddr decRs1Addr,
    input  RegAddr decRs2Addr,
    input  logic   decUsesRs1,
    input  logic   decUsesRs2,
    input  RegAddr exeRdAddr,
    input  logic   exeIsLoad,
    output logic   hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = decUsesRs1 && (decRs1Addr == exeRdAddr);
    assign rs2_hit = decUsesRs2 && (decRs2Addr == exeRdAddr);
    assign hazard  = exeIsLoad && (exeRdAddr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Handles data-memory waits, branch-mispredict redirects and load-use hazards.
// Ports:
//   clk, rst (async, active-low)
//   decRs1Addr/decRs2Addr/decUsesRs1/decUsesRs2 : decode operand info
//   exeRdAddr/exeIsLoad/exeMispredict            : execute instruction info
//   memReq/memReady                              : data-memory handshake
//   fetch/decode/execute/memoryStall             : hold the stage
//   fetchVirtualStall                            : decode loads a bubble while fetch refills
//   decodeFlush/executeFlush/wbFlush             : zero the stage pipeReg
//   memTimeout                                   : sticky memory-wait timeout flag
//   stallCycles                                  : saturating count of fetchStall cycles
//   state                                        : current sequencer state (debug)
// Memory handshake: memReq is held by the memory stage for as long as it holds a
// load/store; the access completes in the cycle memReady is 1 together with memReq.
// Any cycle with memReq=1 and memReady=0 is a wait cycle that freezes the pipeline.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255
)
(
    input  logic           clk,
    input  logic           rst,
    input  RegAddr         decRs1Addr,
    input  RegAddr         decRs2Addr,
    input  logic           decUsesRs1,
    input  logic           decUsesRs2,
    input  RegAddr         exeRdAddr,
    input  logic           exeIsLoad,
    input  logic           exeMispredict,
    input  logic           memReq,
    input  logic           memReady,
    output logic           fetchStall,
    output logic           decodeStall,
    output logic           executeStall,
    output logic           memoryStall,
    output logic           fetchVirtualStall,
    output logic           decodeFlush,
    output logic           executeFlush,
    output logic           wbFlush,
    output logic           memTimeout,
    output logic [31:0]    stallCycles,
    output ControllerState state
);

    localparam logic [2:0]  REDIR_LOAD    = 3'(REDIRECT_CYCLES);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

    ControllerState state_q, state_d;
    logic [2:0]     redir_q, redir_d;
    logic [15:0]    tmo_q, tmo_d;
    logic           timeout_q, timeout_d;
    logic [31:0]    stall_cnt_q;

    logic load_use;
    logic mem_wait;

    logic f_stall, d_stall, e_stall, m_stall, fv_stall;
    logic d_flush, e_flush, w_flush;

    pipeline_hazard_controller_load_use_detector u_load_use_detector (
        .decRs1Addr (decRs1Addr),
        .decRs2Addr (decRs2Addr),
        .decUsesRs1 (decUsesRs1),
        .decUsesRs2 (decUsesRs2),
        .exeRdAddr  (exeRdAddr),
        .exeIsLoad  (exeIsLoad),
        .hazard     (load_use)
    );

    assign mem_wait = memReq && !memReady;

    always_comb begin
        state_d   = state_q;
        redir_d   = redir_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        f_stall   = 1'b0;
        d_stall   = 1'b0;
        e_stall   = 1'b0;
        m_stall   = 1'b0;
        fv_stall  = 1'b0;
        d_flush   = 1'b0;
        e_flush   = 1'b0;
        w_flush   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
                    w_flush = 1'b1;
                    state_d = MEM_WAIT;
                    tmo_d   = '0;
                end else if (exeMispredict) begin
                    d_flush = 1'b1;
                    e_flush = 1'b1;
                    if (REDIRECT_CYCLES > 0) begin
                        state_d = REDIRECT;
                        redir_d = REDIR_LOAD;
                    end
                end else if (load_use) begin
                    // One bubble is enough: the load moves to memory next cycle.
                    f_stall = 1'b1;
                    d_stall = 1'b1;
                    e_flush = 1'b1;
                end
            end

            MEM_WAIT: begin
                // Execute is frozen, so a pending mispredict simply waits for RUN.
                if (tmo_q != 16'hFFFF) begin
                    tmo_d = tmo_q + 16'd1;
                end
                if (tmo_d >= TIMEOUT_LIMIT) begin
                    timeout_d = 1'b1;
                end
                if (memReady) begin
                    state_d = RUN;
                end else begin
                    {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
                    w_flush = 1'b1;
                end
            end

            REDIRECT: begin
                if (mem_wait) begin
                    {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
                    w_flush = 1'b1;
                    state_d = MEM_WAIT;
                    tmo_d   = '0;
                    redir_d = '0;
                end else begin
                    fv_stall = 1'b1;
                    if (exeMispredict) begin
                        // Decode already holds a bubble; only execute needs clearing.
                        e_flush = 1'b1;
                        redir_d = REDIR_LOAD;
                    end else if (redir_q <= 3'd1) begin
                        state_d = RUN;
                        redir_d = '0;
                    end else begin
                        redir_d = redir_q - 3'd1;
                    end
                end
            end

            default: begin
                state_d = RUN;
                redir_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            redir_q     <= '0;
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            redir_q   <= redir_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            if (f_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    // While reset is held the stages clear themselves, so every control is quiet.
    assign fetchStall        = rst && f_stall;
    assign decodeStall       = rst && d_stall;
    assign executeStall      = rst && e_stall;
    assign memoryStall       = rst && m_stall;
    assign fetchVirtualStall = rst && fv_stall;
    assign decodeFlush       = rst && d_flush;
    assign executeFlush      = rst && e_flush;
    assign wbFlush           = rst && w_flush;

    assign memTimeout  = timeout_q;
    assign stallCycles = stall_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (REDIRECT_CYCLES=2, MEM_TIMEOUT=8).
// Output vector order: {fetchStall, decodeStall, executeStall, memoryStall,
//                       fetchVirtualStall, decodeFlush, executeFlush, wbFlush}
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    localparam logic [7:0] V_NONE = 8'b0000_0000;
    localparam logic [7:0] V_MEM  = 8'b1111_0001;
    localparam logic [7:0] V_LU   = 8'b1100_0010;
    localparam logic [7:0] V_MP   = 8'b0000_0110;
    localparam logic [7:0] V_FV   = 8'b0000_1000;
    localparam logic [7:0] V_RF   = 8'b0000_1010;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    RegAddr         decRs1Addr, decRs2Addr, exeRdAddr;
    logic           decUsesRs1, decUsesRs2, exeIsLoad, exeMispredict, memReq, memReady;
    logic           fetchStall, decodeStall, executeStall, memoryStall, fetchVirtualStall;
    logic           decodeFlush, executeFlush, wbFlush, memTimeout;
    logic [31:0]    stallCycles;
    ControllerState state;
    logic [7:0]     outs;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stalls = 0;

    pipeline_hazard_controller #(
        .REDIRECT_CYCLES (2),
        .MEM_TIMEOUT     (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .decRs1Addr        (decRs1Addr),
        .decRs2Addr        (decRs2Addr),
        .decUsesRs1        (decUsesRs1),
        .decUsesRs2        (decUsesRs2),
        .exeRdAddr         (exeRdAddr),
        .exeIsLoad         (exeIsLoad),
        .exeMispredict     (exeMispredict),
        .memReq            (memReq),
        .memReady          (memReady),
        .fetchStall        (fetchStall),
        .decodeStall       (decodeStall),
        .executeStall      (executeStall),
        .memoryStall       (memoryStall),
        .fetchVirtualStall (fetchVirtualStall),
        .decodeFlush       (decodeFlush),
        .executeFlush      (executeFlush),
        .wbFlush           (wbFlush),
        .memTimeout        (memTimeout),
        .stallCycles       (stallCycles),
        .state             (state)
    );

    assign outs = {fetchStall, decodeStall, executeStall, memoryStall,
                   fetchVirtualStall, decodeFlush, executeFlush, wbFlush};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input ControllerState exp);
        check(tag, 32'(state), 32'(exp));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        decRs1Addr    = '0;
        decRs2Addr    = '0;
        decUsesRs1    = 1'b0;
        decUsesRs2    = 1'b0;
        exeRdAddr     = '0;
        exeIsLoad     = 1'b0;
        exeMispredict = 1'b0;
        memReq        = 1'b0;
        memReady      = 1'b0;
    endtask

    // Inputs are already applied; check this cycle's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [7:0] exp_v);
        #1;
        check(tag, 32'(outs), 32'(exp_v));
        if (exp_v[7]) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input RegAddr rd, input logic u1, input RegAddr a1,
                                input logic u2, input RegAddr a2);
        drive_idle();
        exeIsLoad  = 1'b1;
        exeRdAddr  = rd;
        decUsesRs1 = u1;
        decRs1Addr = a1;
        decUsesRs2 = u2;
        decRs2Addr = a2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        rst    = 1'b0;
        memReq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs), 32'(V_NONE));
        check_state("rst_state", RUN);
        check("rst_stallcnt", stallCycles, 32'd0);
        check("rst_timeout", 32'(memTimeout), 32'd0);
        rst = 1'b1;
        drive_idle();
        cyc("idle", V_NONE);

        // Load-use on rs2, then the hazard disappears.
        set_load_use(5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        cyc("lu_rs2", V_LU);
        check_state("lu_state", RUN);
        check("lu_stallcnt", stallCycles, 32'd1);
        drive_idle();
        cyc("lu_clear", V_NONE);
        // Load-use on rs1.
        set_load_use(5'd7, 1'b1, 5'd7, 1'b0, 5'd3);
        cyc("lu_rs1", V_LU);
        // Register 0 never hazards.
        set_load_use(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cyc("lu_x0", V_NONE);
        // Matching address but operand not read.
        set_load_use(5'd9, 1'b0, 5'd9, 1'b0, 5'd9);
        cyc("lu_unused", V_NONE);
        // Not a load.
        set_load_use(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        exeIsLoad = 1'b0;
        cyc("lu_notload", V_NONE);
        check("lu_stallcnt2", stallCycles, 32'(exp_stalls));

        // Memory wait: 4 low memReady cycles, then release.
        drive_idle();
        memReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("memwait", V_MEM);
            check_state("memwait_state", MEM_WAIT);
        end
        memReady = 1'b1;
        cyc("mem_release", V_NONE);
        check_state("mem_release_state", RUN);
        drive_idle();
        cyc("mem_after", V_NONE);
        check("mem_stallcnt", stallCycles, 32'(exp_stalls));
        check("mem_no_timeout", 32'(memTimeout), 32'd0);

        // Timeout after the 8th MEM_WAIT cycle, sticky past memReady.
        memReq = 1'b1;
        cyc("tmo_enter", V_MEM);
        for (int i = 0; i < 8; i++) begin
            check("tmo_low", 32'(memTimeout), 32'd0);
            cyc("tmo_wait", V_MEM);
        end
        check("tmo_high", 32'(memTimeout), 32'd1);
        memReady = 1'b1;
        cyc("tmo_release", V_NONE);
        drive_idle();
        cyc("tmo_idle", V_NONE);
        check("tmo_sticky", 32'(memTimeout), 32'd1);
        check("tmo_stallcnt", stallCycles, 32'(exp_stalls));

        // Redirect: flush, then two bubble cycles.
        exeMispredict = 1'b1;
        cyc("mp_flush", V_MP);
        exeMispredict = 1'b0;
        check_state("mp_state", REDIRECT);
        cyc("mp_fv1", V_FV);
        cyc("mp_fv2", V_FV);
        check_state("mp_back", RUN);
        cyc("mp_done", V_NONE);

        // A second mispredict in REDIRECT reloads the counter.
        exeMispredict = 1'b1;
        cyc("rl_flush", V_MP);
        exeMispredict = 1'b0;
        cyc("rl_fv1", V_FV);
        exeMispredict = 1'b1;
        cyc("rl_reload", V_RF);
        exeMispredict = 1'b0;
        cyc("rl_fv2", V_FV);
        cyc("rl_fv3", V_FV);
        cyc("rl_done", V_NONE);

        // Mispredict + load-use: flush only.
        set_load_use(5'd4, 1'b1, 5'd4, 1'b0, 5'd0);
        exeMispredict = 1'b1;
        cyc("mplu_flush", V_MP);
        drive_idle();
        cyc("mplu_fv1", V_FV);
        cyc("mplu_fv2", V_FV);
        cyc("mplu_done", V_NONE);

        // Mispredict + memWait: wait first, flush in the first RUN cycle.
        exeMispredict = 1'b1;
        memReq        = 1'b1;
        cyc("mpmw_run", V_MEM);
        cyc("mpmw_wait", V_MEM);
        memReady = 1'b1;
        cyc("mpmw_release", V_NONE);
        memReq   = 1'b0;
        memReady = 1'b0;
        cyc("mpmw_flush", V_MP);
        exeMispredict = 1'b0;
        cyc("mpmw_fv1", V_FV);
        cyc("mpmw_fv2", V_FV);
        cyc("mpmw_done", V_NONE);

        // memWait preempts REDIRECT.
        exeMispredict = 1'b1;
        cyc("pre_flush", V_MP);
        exeMispredict = 1'b0;
        memReq        = 1'b1;
        cyc("pre_mem", V_MEM);
        check_state("pre_state", MEM_WAIT);
        memReady = 1'b1;
        cyc("pre_release", V_NONE);
        drive_idle();
        cyc("pre_idle", V_NONE);
        check("pre_stallcnt", stallCycles, 32'(exp_stalls));

        // Async reset in MEM_WAIT.
        memReq = 1'b1;
        cyc("ar_mem", V_MEM);
        rst = 1'b0;
        #1;
        check_state("ar_mem_state", RUN);
        check("ar_mem_outs", 32'(outs), 32'(V_NONE));
        check("ar_mem_cnt", stallCycles, 32'd0);
        check("ar_mem_tmo", 32'(memTimeout), 32'd0);
        exp_stalls = 0;
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("ar_mem_after", V_NONE);

        // Async reset in REDIRECT.
        exeMispredict = 1'b1;
        cyc("ar_rd_flush", V_MP);
        exeMispredict = 1'b0;
        rst = 1'b0;
        #1;
        check_state("ar_rd_state", RUN);
        check("ar_rd_outs", 32'(outs), 32'(V_NONE));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("ar_rd_after", V_NONE);
        check("final_stallcnt", stallCycles, 32'(exp_stalls));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
